// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle datapath and its controller.
// The datapath (master) supplies instruction fields and flags; the controller (slave) returns enables and selects.
interface multicycle_ctrl_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       zero;
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] imm_src;
  logic       illegal;

  modport master (
    output op, funct3, zero,
    input  pc_write, adr_src, mem_write, ir_write, reg_write,
           result_src, alu_src_a, alu_src_b, alu_op, imm_src, illegal
  );

  modport slave (
    input  op, funct3, zero,
    output pc_write, adr_src, mem_write, ir_write, reg_write,
           result_src, alu_src_a, alu_src_b, alu_op, imm_src, illegal
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main FSM of a multicycle RV32I-subset core: sequences fetch, decode, memory,
// ALU, branch and jal steps and drives every datapath enable and mux select.
module multicycle_ctrl #(
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  multicycle_ctrl_if.slave   ctrl
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_ILLEGAL
  } state_t;

  state_t r_state;
  state_t w_next;

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // the pre-edge values; reset is synchronous, so it lives inside the clocked branch.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    w_next          = r_state;
    ctrl.pc_write   = 1'b0;
    ctrl.adr_src    = 1'b0;
    ctrl.mem_write  = 1'b0;
    ctrl.ir_write   = 1'b0;
    ctrl.reg_write  = 1'b0;
    ctrl.result_src = 2'b00;
    ctrl.alu_src_a  = 2'b00;
    ctrl.alu_src_b  = 2'b00;
    ctrl.alu_op     = 2'b00;
    ctrl.imm_src    = 2'b00;
    ctrl.illegal    = 1'b0;

    case (r_state)
      S_FETCH:    w_next = S_DECODE;
      S_DECODE: begin
        case (ctrl.op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECR;
          OP_I:         w_next = S_EXECI;
          OP_BR:        w_next = S_BRANCH;
          OP_JAL:       w_next = S_JAL;
          default:      w_next = HALT_ON_ILLEGAL ? S_ILLEGAL : S_FETCH;
        endcase
      end
      S_MEMADR:   w_next = (ctrl.op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  w_next = S_MEMWB;
      S_EXECR,
      S_EXECI,
      S_JAL:      w_next = S_ALUWB;
      S_ILLEGAL:  w_next = S_ILLEGAL;
      default:    w_next = S_FETCH;
    endcase

    // Reset is synchronous, so outputs are gated here to stay quiet during the
    // reset cycle even while the register still holds a mid-instruction state.
    if (!reset) begin
      case (ctrl.op)
        OP_SW:   ctrl.imm_src = 2'b01;
        OP_BR:   ctrl.imm_src = 2'b10;
        OP_JAL:  ctrl.imm_src = 2'b11;
        default: ctrl.imm_src = 2'b00;
      endcase

      case (r_state)
        S_FETCH: begin
          ctrl.ir_write   = 1'b1;
          ctrl.alu_src_b  = 2'b10;
          ctrl.result_src = 2'b10;
          ctrl.pc_write   = 1'b1;
        end
        S_DECODE: begin
          ctrl.alu_src_a = 2'b01;
          ctrl.alu_src_b = 2'b01;
        end
        S_MEMADR: begin
          ctrl.alu_src_a = 2'b10;
          ctrl.alu_src_b = 2'b01;
        end
        S_MEMREAD:  ctrl.adr_src = 1'b1;
        S_MEMWB: begin
          ctrl.result_src = 2'b01;
          ctrl.reg_write  = 1'b1;
        end
        S_MEMWRITE: begin
          ctrl.adr_src   = 1'b1;
          ctrl.mem_write = 1'b1;
        end
        S_EXECR: begin
          ctrl.alu_src_a = 2'b10;
          ctrl.alu_op    = 2'b10;
        end
        S_EXECI: begin
          ctrl.alu_src_a = 2'b10;
          ctrl.alu_src_b = 2'b01;
          ctrl.alu_op    = 2'b10;
        end
        S_ALUWB:    ctrl.reg_write = 1'b1;
        S_BRANCH: begin
          // funct3[0] turns beq into bne by inverting the zero test.
          ctrl.alu_src_a = 2'b10;
          ctrl.alu_op    = 2'b01;
          ctrl.pc_write  = ctrl.zero ^ ctrl.funct3[0];
        end
        S_JAL: begin
          ctrl.alu_src_a = 2'b01;
          ctrl.alu_src_b = 2'b10;
          ctrl.pc_write  = 1'b1;
        end
        S_ILLEGAL:  ctrl.illegal = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle expected control vectors
// are queued per scenario and compared against the DUT outputs mid-cycle.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] imm_src;
    logic       illegal;
  } ctrl_t;

  localparam ctrl_t C_ZERO    = '0;
  localparam ctrl_t C_FETCH   = '{pc_write:1'b1, ir_write:1'b1, result_src:2'b10, alu_src_b:2'b10, default:'0};
  localparam ctrl_t C_DECODE  = '{alu_src_a:2'b01, alu_src_b:2'b01, default:'0};
  localparam ctrl_t C_MEMADR  = '{alu_src_a:2'b10, alu_src_b:2'b01, default:'0};
  localparam ctrl_t C_MEMREAD = '{adr_src:1'b1, default:'0};
  localparam ctrl_t C_MEMWB   = '{result_src:2'b01, reg_write:1'b1, default:'0};
  localparam ctrl_t C_MEMWR   = '{adr_src:1'b1, mem_write:1'b1, default:'0};
  localparam ctrl_t C_EXECR   = '{alu_src_a:2'b10, alu_op:2'b10, default:'0};
  localparam ctrl_t C_EXECI   = '{alu_src_a:2'b10, alu_src_b:2'b01, alu_op:2'b10, default:'0};
  localparam ctrl_t C_ALUWB   = '{reg_write:1'b1, default:'0};
  localparam ctrl_t C_BRANCH  = '{alu_src_a:2'b10, alu_op:2'b01, default:'0};
  localparam ctrl_t C_JAL     = '{alu_src_a:2'b01, alu_src_b:2'b10, pc_write:1'b1, default:'0};
  localparam ctrl_t C_ILLEGAL = '{illegal:1'b1, default:'0};

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;
  ctrl_t exp_q[$];
  ctrl_t exp_v;
  ctrl_t obs_v;

  multicycle_ctrl_if bus ();
  multicycle_ctrl_if bus_nh ();

  assign bus_nh.op     = bus.op;
  assign bus_nh.funct3 = bus.funct3;
  assign bus_nh.zero   = bus.zero;

  multicycle_ctrl #(.HALT_ON_ILLEGAL(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .ctrl  (bus)
  );

  multicycle_ctrl #(.HALT_ON_ILLEGAL(1'b0)) dut_nh (
    .clk   (clk),
    .reset (reset),
    .ctrl  (bus_nh)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] imm_of(input logic [6:0] op);
    case (op)
      OP_SW:   return 2'b01;
      OP_BR:   return 2'b10;
      OP_JAL:  return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic ctrl_t sample_main();
    ctrl_t s;
    s = '{pc_write:bus.pc_write, adr_src:bus.adr_src, mem_write:bus.mem_write,
          ir_write:bus.ir_write, reg_write:bus.reg_write, result_src:bus.result_src,
          alu_src_a:bus.alu_src_a, alu_src_b:bus.alu_src_b, alu_op:bus.alu_op,
          imm_src:bus.imm_src, illegal:bus.illegal};
    return s;
  endfunction

  function automatic ctrl_t sample_nh();
    ctrl_t s;
    s = '{pc_write:bus_nh.pc_write, adr_src:bus_nh.adr_src, mem_write:bus_nh.mem_write,
          ir_write:bus_nh.ir_write, reg_write:bus_nh.reg_write, result_src:bus_nh.result_src,
          alu_src_a:bus_nh.alu_src_a, alu_src_b:bus_nh.alu_src_b, alu_op:bus_nh.alu_op,
          imm_src:bus_nh.imm_src, illegal:bus_nh.illegal};
    return s;
  endfunction

  // Queue the expected vector for one cycle, with imm_src following the opcode.
  task automatic push(input ctrl_t c, input logic [6:0] op);
    ctrl_t e;
    e = c;
    e.imm_src = imm_of(op);
    exp_q.push_back(e);
  endtask

  task automatic set_in(input logic [6:0] op, input logic [2:0] f3, input logic z);
    bus.op     = op;
    bus.funct3 = f3;
    bus.zero   = z;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_in(OP_SW, 3'b000, 1'b1);
    repeat (2) @(negedge clk);
    #1;
    obs_v = sample_main();
    n_cmp++;
    if (obs_v !== C_ZERO) begin
      n_bad++;
      $display("FAIL reset_outputs got=%h want=%h", obs_v, C_ZERO);
    end
    @(negedge clk);
    reset = 1'b0;
    set_in(OP_R, 3'b000, 1'b0);
    push(C_FETCH, OP_R);
    #1;
    exp_v = exp_q.pop_front();
    obs_v = sample_main();
    n_cmp++;
    if (obs_v !== exp_v) begin
      n_bad++;
      $display("FAIL first_fetch got=%h want=%h", obs_v, exp_v);
    end
    // Finish the R-type so the next scenario starts on a FETCH boundary.
    push(C_EXECR, OP_R);
    push(C_ALUWB, OP_R);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      #1;
      exp_v = exp_q.pop_front();
      obs_v = sample_main();
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL rtype_tail cycle=%0d got=%h want=%h", i + 3, obs_v, exp_v);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_lw();
    set_in(OP_LW, 3'b010, 1'b0);
    push(C_FETCH, OP_LW);
    push(C_DECODE, OP_LW);
    push(C_MEMADR, OP_LW);
    push(C_MEMREAD, OP_LW);
    push(C_MEMWB, OP_LW);
    for (int i = 0; i < 5; i++) begin
      #1;
      exp_v = exp_q.pop_front();
      obs_v = sample_main();
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL lw cycle=%0d got=%h want=%h", i + 1, obs_v, exp_v);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_sw();
    set_in(OP_SW, 3'b010, 1'b0);
    push(C_FETCH, OP_SW);
    push(C_DECODE, OP_SW);
    push(C_MEMADR, OP_SW);
    push(C_MEMWR, OP_SW);
    for (int i = 0; i < 4; i++) begin
      #1;
      exp_v = exp_q.pop_front();
      obs_v = sample_main();
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL sw cycle=%0d got=%h want=%h", i + 1, obs_v, exp_v);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_branch();
    logic [1:0] combo;
    for (int k = 0; k < 4; k++) begin
      combo = 2'(k);
      set_in(OP_BR, {2'b00, combo[1]}, combo[0]);
      push(C_FETCH, OP_BR);
      push(C_DECODE, OP_BR);
      exp_v = C_BRANCH;
      exp_v.pc_write = combo[0] ^ combo[1];
      push(exp_v, OP_BR);
      for (int i = 0; i < 3; i++) begin
        #1;
        exp_v = exp_q.pop_front();
        obs_v = sample_main();
        n_cmp++;
        if (obs_v !== exp_v) begin
          n_bad++;
          $display("FAIL branch f3_0=%0b zero=%0b cycle=%0d got=%h want=%h",
                   combo[1], combo[0], i + 1, obs_v, exp_v);
        end
        @(negedge clk);
      end
    end
  endtask

  // R-type, I-type and jal issued with no gap; opcode changes at each FETCH.
  task automatic test_back_to_back();
    logic [6:0] sched [12];
    for (int i = 0; i < 4; i++) begin
      sched[i]     = OP_R;
      sched[i + 4] = OP_I;
      sched[i + 8] = OP_JAL;
    end
    push(C_FETCH, OP_R);   push(C_DECODE, OP_R);   push(C_EXECR, OP_R);  push(C_ALUWB, OP_R);
    push(C_FETCH, OP_I);   push(C_DECODE, OP_I);   push(C_EXECI, OP_I);  push(C_ALUWB, OP_I);
    push(C_FETCH, OP_JAL); push(C_DECODE, OP_JAL); push(C_JAL, OP_JAL);  push(C_ALUWB, OP_JAL);
    for (int i = 0; i < 12; i++) begin
      set_in(sched[i], 3'b000, 1'b0);
      #1;
      exp_v = exp_q.pop_front();
      obs_v = sample_main();
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL b2b cycle=%0d op=%b got=%h want=%h", i + 1, sched[i], obs_v, exp_v);
      end
      @(negedge clk);
    end
    // After jal's writeback the controller must be back in FETCH.
    set_in(OP_LW, 3'b000, 1'b0);
    push(C_FETCH, OP_LW);
    #1;
    exp_v = exp_q.pop_front();
    obs_v = sample_main();
    n_cmp++;
    if (obs_v !== exp_v) begin
      n_bad++;
      $display("FAIL jal_return got=%h want=%h", obs_v, exp_v);
    end
    // Drain the lw so the next scenario begins at FETCH.
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    set_in(OP_SW, 3'b010, 1'b0);
    repeat (3) @(negedge clk);
    push(C_MEMWR, OP_SW);
    #1;
    exp_v = exp_q.pop_front();
    obs_v = sample_main();
    n_cmp++;
    if (obs_v !== exp_v) begin
      n_bad++;
      $display("FAIL memwrite_pre_reset got=%h want=%h", obs_v, exp_v);
    end
    reset = 1'b1;
    #1;
    obs_v = sample_main();
    n_cmp++;
    if (obs_v !== C_ZERO) begin
      n_bad++;
      $display("FAIL memwrite_during_reset got=%h want=%h", obs_v, C_ZERO);
    end
    @(negedge clk);
    reset = 1'b0;
    push(C_FETCH, OP_SW);
    #1;
    exp_v = exp_q.pop_front();
    obs_v = sample_main();
    n_cmp++;
    if (obs_v !== exp_v) begin
      n_bad++;
      $display("FAIL fetch_after_mid_reset got=%h want=%h", obs_v, exp_v);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_illegal();
    set_in(OP_BAD, 3'b000, 1'b0);
    push(C_FETCH, OP_BAD);
    push(C_DECODE, OP_BAD);
    repeat (10) push(C_ILLEGAL, OP_BAD);
    for (int i = 0; i < 12; i++) begin
      #1;
      exp_v = exp_q.pop_front();
      obs_v = sample_main();
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("FAIL illegal_halt cycle=%0d got=%h want=%h", i + 1, obs_v, exp_v);
      end
      if (i == 2) begin
        // Non-halting variant falls straight back to FETCH instead.
        obs_v = sample_nh();
        n_cmp++;
        if (obs_v !== C_FETCH) begin
          n_bad++;
          $display("FAIL illegal_nohalt got=%h want=%h", obs_v, C_FETCH);
        end
      end
      @(negedge clk);
    end
    reset = 1'b1;
    #1;
    obs_v = sample_main();
    n_cmp++;
    if (obs_v !== C_ZERO) begin
      n_bad++;
      $display("FAIL illegal_reset got=%h want=%h", obs_v, C_ZERO);
    end
    @(negedge clk);
    reset = 1'b0;
    set_in(OP_I, 3'b000, 1'b0);
    push(C_FETCH, OP_I);
    #1;
    exp_v = exp_q.pop_front();
    obs_v = sample_main();
    n_cmp++;
    if (obs_v !== exp_v) begin
      n_bad++;
      $display("FAIL illegal_recover got=%h want=%h", obs_v, exp_v);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_lw();
    test_sw();
    test_branch();
    test_back_to_back();
    test_reset_mid();
    test_illegal();
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter HALT_ON_ILLEGAL, default 1; 1 = illegal opcode parks the FSM in ILLEGAL, 0 = illegal opcode returns to FETCH.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  synchronous, active-high; clock clk.
REQ-004 op  input  7  opcode field of the instruction register.
REQ-005 funct3  input  3  funct3 field; bit 0 selects bne (1) vs beq (0).
REQ-006 zero  input  1  ALU zero flag, valid in the BRANCH cycle.
REQ-007 pc_write  output  1  PC register load enable.
REQ-008 adr_src  output  1  memory address select: 0 PC, 1 ALUOut.
REQ-009 mem_write  output  1  data memory write enable.
REQ-010 ir_write  output  1  instruction/old-PC register load enable.
REQ-011 reg_write  output  1  register file write enable.
REQ-012 result_src  output  2  00 ALUOut, 01 Data, 10 ALUResult.
REQ-013 alu_src_a  output  2  00 PC, 01 OldPC, 10 RD1.
REQ-014 alu_src_b  output  2  00 RD2, 01 ImmExt, 10 constant 4.
REQ-015 alu_op  output  2  00 add, 01 subtract, 10 funct decode.
REQ-016 imm_src  output  2  combinational from op: I/lw 00, sw 01, branch 10, jal 11, others 00.
REQ-017 illegal  output  1  high while in state ILLEGAL.

Function
REQ-018 State register SHALL hold one of: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, ILLEGAL.
REQ-019 Transitions: FETCH->DECODE always.
REQ-020 DECODE -> MEMADR (op 0000011 or 0100011), EXECR (0110011), EXECI (0010011), BRANCH (1100011), JAL (1101111), otherwise ILLEGAL if HALT_ON_ILLEGAL=1, else FETCH.
REQ-021 MEMADR -> MEMREAD for op 0000011, MEMWRITE for op 0100011.
REQ-022 MEMREAD->MEMWB; MEMWB, MEMWRITE, BRANCH -> FETCH; EXECR, EXECI, JAL -> ALUWB; ALUWB->FETCH; ILLEGAL->ILLEGAL.
REQ-023 FETCH SHALL assert adr_src=0, ir_write=1, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10, pc_write=1.
REQ-024 DECODE SHALL assert alu_src_a=01, alu_src_b=01, alu_op=00 (branch/jump target precompute); no write enables.
REQ-025 MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00.
REQ-026 MEMREAD: result_src=00, adr_src=1.
REQ-027 MEMWB: result_src=01, reg_write=1.
REQ-028 MEMWRITE: result_src=00, adr_src=1, mem_write=1.
REQ-029 EXECR: alu_src_a=10, alu_src_b=00, alu_op=10.
REQ-030 EXECI: alu_src_a=10, alu_src_b=01, alu_op=10.
REQ-031 ALUWB: result_src=00, reg_write=1.
REQ-032 BRANCH: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, pc_write=(zero XOR funct3[0]) in that same cycle.
REQ-033 JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1.
REQ-034 Any output not listed for a state SHALL be 0; pc_write is the only output depending on a non-state input (zero, funct3).
REQ-035 Instruction latency from FETCH to next FETCH: lw 5, sw 4, R-type 4, I-type 4, branch 3, jal 4 cycles.
REQ-036 ILLEGAL SHALL drive all enables 0 and illegal=1 until reset.

Reset
REQ-037 reset high at a clock edge SHALL load state FETCH, regardless of current state, including mid-instruction.
REQ-038 While reset is high, pc_write, mem_write, ir_write, reg_write SHALL be forced 0; all select outputs 0; illegal 0.
REQ-039 First cycle after reset deassertion SHALL be FETCH with REQ-023 outputs.

Verification
REQ-040 Reset then op=0000011 -> states FETCH,DECODE,MEMADR,MEMREAD,MEMWB; reg_write=1 only in cycle 5, result_src=01.
REQ-041 op=0100011 -> mem_write=1 only in cycle 4 with adr_src=1; reg_write never asserted.
REQ-042 op=1100011, funct3=000, zero=1 -> pc_write=1 in cycle 3; zero=0 -> pc_write=0; funct3=001 inverts both.
REQ-043 op=1101111 -> pc_write=1 in cycles 1 and 3, reg_write=1 in cycle 4, then FETCH.
REQ-044 op=1111111 with HALT_ON_ILLEGAL=1 -> illegal=1 from cycle 3, all enables 0 for 10 cycles; reset -> FETCH.
REQ-045 reset asserted during MEMWRITE -> mem_write=0 that cycle, FETCH next cycle after deassertion.
